// File: rtl/pressure_pkg.sv
// pressure_pkg
// Shared definitions for the pressure-sensor sample controller:
//   - sequencer state encoding
//   - default data / period / confirm-count widths
//   - default conversion watchdog limit
package pressure_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_START   = 2'd2,
    S_CONVERT = 2'd3
  } state_t;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_CONF_W   = 4;

  // Longest a conversion may stay outstanding before it is declared dead.
  localparam int DEF_TIMEOUT  = 1023;

endpackage

// File: rtl/pressure_sample_ctrl_hyst_filter.sv
// pressure_hyst_filter
// Two-threshold hysteresis filter with N-consecutive-sample confirmation.
// Ports:
//   clk, reset      clock, async active-high reset
//   update          one-cycle strobe: sample is a new accepted conversion
//   sample          conversion result
//   hi_thresh       alarm-set threshold (sample >= hi_thresh qualifies)
//   lo_thresh       alarm-clear threshold (sample <= lo_thresh qualifies)
//   confirm_n       consecutive qualifying samples to switch alarm (0 acts as 1)
//   alarm           registered filtered alarm
module pressure_hyst_filter
  import pressure_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CONF_W = DEF_CONF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] hi_thresh,
  input  logic [DATA_W-1:0] lo_thresh,
  input  logic [CONF_W-1:0] confirm_n,
  output logic              alarm
);

  localparam logic [CONF_W-1:0] CNT_MAX = '1;

  logic [CONF_W-1:0] hi_cnt;
  logic [CONF_W-1:0] lo_cnt;
  logic [CONF_W-1:0] hi_nxt;
  logic [CONF_W-1:0] lo_nxt;
  logic [CONF_W-1:0] conf_eff;

  // Next counter values for the sample being accepted. The alarm decision
  // uses these, so a confirm count of 1 switches on the first qualifying
  // sample. The high side wins if a misconfigured threshold pair lets one
  // sample qualify for both.
  always_comb begin
    hi_nxt   = '0;
    lo_nxt   = '0;
    conf_eff = (confirm_n == '0) ? CONF_W'(1) : confirm_n;
    if (sample >= hi_thresh) begin
      hi_nxt = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;
    end else if (sample <= lo_thresh) begin
      lo_nxt = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + 1'b1;
    end
  end

  // >= rather than == so that lowering confirm_n below an already
  // saturated run still lets the next qualifying sample switch the alarm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      alarm  <= 1'b0;
    end else if (update) begin
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
      if (hi_nxt >= conf_eff) begin
        alarm <= 1'b1;
      end else if (lo_nxt >= conf_eff) begin
        alarm <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pressure_sample_ctrl.sv
// pressure_sample_ctrl
// Periodic ADC sequencer for the pressure front end: triggers a conversion,
// latches the result, feeds the hysteresis filter and watches for
// conversions that never complete.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | stopped; enable=1 starts a conversion at once
// S_WAIT    | counting down sample_period between conversions
// S_START   | adc_start asserted for this single cycle
// S_CONVERT | waiting for adc_done; watchdog running
//
// Ports:
//   clk, reset     clock, async active-high reset
//   enable         run control (level)
//   sample_period  idle cycles between a conversion ending and next adc_start
//   hi_thresh      alarm-set threshold
//   lo_thresh      alarm-clear threshold
//   confirm_n      consecutive qualifying samples to switch alarm
//   adc_start      one-cycle conversion request
//   adc_done       one-cycle conversion-complete strobe
//   adc_data       conversion result, valid with adc_done
//   sample_q       last latched sample
//   sample_valid   one-cycle pulse when sample_q updates
//   alarm          filtered over-pressure flag
//   fault          sticky conversion-timeout flag
//   busy           high while in S_START or S_CONVERT
module pressure_sample_ctrl
  import pressure_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int CONF_W   = DEF_CONF_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [DATA_W-1:0]   hi_thresh,
  input  logic [DATA_W-1:0]   lo_thresh,
  input  logic [CONF_W-1:0]   confirm_n,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  output logic [DATA_W-1:0]   sample_q,
  output logic                sample_valid,
  output logic                alarm,
  output logic                fault,
  output logic                busy
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [PERIOD_W-1:0] period_cnt;
  logic [WDOG_W-1:0]   wdog;
  logic                wdog_expired;
  logic                accept;

  // The watchdog holds the count of CONVERT cycles already elapsed; the
  // edge that would make it TIMEOUT is the one that abandons the conversion.
  assign wdog_expired = (wdog == WDOG_W'(TIMEOUT - 1));

  // adc_done is only meaningful while a conversion is outstanding.
  assign accept = (state == S_CONVERT) && adc_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      adc_start    <= 1'b0;
      busy         <= 1'b0;
      sample_q     <= '0;
      sample_valid <= 1'b0;
      fault        <= 1'b0;
      period_cnt   <= '0;
      wdog         <= '0;
    end else begin
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_START;
            adc_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (period_cnt == '0) begin
            state     <= S_START;
            adc_start <= 1'b1;
            busy      <= 1'b1;
          end else begin
            period_cnt <= period_cnt - 1'b1;
          end
        end
        S_START: begin
          // enable is deliberately ignored here: a requested conversion
          // always runs to completion or timeout.
          state <= S_CONVERT;
          wdog  <= '0;
        end
        S_CONVERT: begin
          if (adc_done || wdog_expired) begin
            if (adc_done) begin
              sample_q     <= adc_data;
              sample_valid <= 1'b1;
            end else begin
              fault <= 1'b1;
            end
            period_cnt <= sample_period;
            busy       <= 1'b0;
            state      <= enable ? S_WAIT : S_IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  pressure_hyst_filter #(
    .DATA_W (DATA_W),
    .CONF_W (CONF_W)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .update    (accept),
    .sample    (adc_data),
    .hi_thresh (hi_thresh),
    .lo_thresh (lo_thresh),
    .confirm_n (confirm_n),
    .alarm     (alarm)
  );

endmodule

// File: tb/tb_pressure_sample_ctrl.sv
// Testbench for pressure_sample_ctrl: ADC responder, scoreboard of expected
// (sample, alarm) pairs, and directed scenarios for period timing, filter
// hysteresis, watchdog timeout, enable drop and async reset.
module tb_pressure_sample_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_period = 16'd3;
  logic [11:0] hi_thresh = 12'd3000;
  logic [11:0] lo_thresh = 12'd1000;
  logic [3:0]  confirm_n = 4'd3;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic [11:0] sample_q;
  logic        sample_valid;
  logic        alarm;
  logic        fault;
  logic        busy;

  pressure_sample_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .sample_period (sample_period),
    .hi_thresh     (hi_thresh),
    .lo_thresh     (lo_thresh),
    .confirm_n     (confirm_n),
    .adc_start     (adc_start),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .sample_q      (sample_q),
    .sample_valid  (sample_valid),
    .alarm         (alarm),
    .fault         (fault),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cycnt = 0;
  always @(posedge clk) cycnt <= cycnt + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] data;
    logic        alarm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int   m_hi = 0;
  int   m_lo = 0;
  logic m_alarm = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural filter: computes the alarm expected once sample s is accepted.
  task automatic push_exp(input logic [11:0] s);
    int   c;
    exp_t e;
    c = (confirm_n == 4'd0) ? 1 : int'(confirm_n);
    if (s >= hi_thresh) begin
      m_hi = (m_hi < 15) ? m_hi + 1 : 15;
      m_lo = 0;
    end else if (s <= lo_thresh) begin
      m_lo = (m_lo < 15) ? m_lo + 1 : 15;
      m_hi = 0;
    end else begin
      m_hi = 0;
      m_lo = 0;
    end
    if (m_hi >= c) m_alarm = 1'b1;
    else if (m_lo >= c) m_alarm = 1'b0;
    e.data  = s;
    e.alarm = m_alarm;
    sb.push_back(e);
  endtask

  // Every sample_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", sample_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("sample_q", sample_q, mon_e.data);
        check("alarm", alarm, mon_e.alarm);
      end
    end
  end

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (adc_start) begin
        cyc = cycnt;
        break;
      end
    end
    if (cyc < 0) check("start_seen", adc_start, 1'b1);
  endtask

  // Answer a conversion whose adc_start was just seen: adc_done is driven
  // dly cycles after the adc_start cycle. td returns the adc_done cycle.
  task automatic answer(input logic [11:0] d, input int dly, input bit drop_en, output int td);
    @(posedge clk); #1;
    check("start_width", adc_start, 1'b0);
    check("busy_conv", busy, 1'b1);
    if (drop_en) enable = 1'b0;
    if (dly > 1) begin
      repeat (dly - 1) @(posedge clk);
      #1;
    end
    adc_done = 1'b1;
    adc_data = d;
    td = cycnt;
    push_exp(d);
    @(posedge clk); #1;
    adc_done = 1'b0;
    adc_data = 12'($urandom_range(0, 4095));
    @(negedge clk); #1;
    check("valid_latency", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic conv(input logic [11:0] d, input int dly, input bit drop_en,
                      output int ts, output int td);
    wait_start(ts);
    answer(d, dly, drop_en, td);
  endtask

  logic [11:0] vals [9] = '{12'd3100, 12'd3200, 12'd2000, 12'd3100, 12'd3100,
                            12'd3100, 12'd900, 12'd900, 12'd900};

  initial begin
    int ts, td, prev_td, cyc_f, ts2, n_st, r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_adc_start", adc_start, 1'b0);
    check("rst_sample_q", sample_q, 12'd0);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_busy", busy, 1'b0);

    @(posedge clk); #1;
    reset  = 1'b0;
    enable = 1'b1;

    // Period timing and confirm_n=3 hysteresis.
    prev_td = 0;
    for (int i = 0; i < 9; i++) begin
      conv(vals[i], 5, 1'b0, ts, td);
      if (i > 0) check("period_gap", ts - prev_td, 5);
      if (i == 0) check("busy_wait", busy, 1'b0);
      if (i == 4) check("alarm_pre_set", alarm, 1'b0);
      if (i == 5) check("alarm_set", alarm, 1'b1);
      if (i == 7) check("alarm_pre_clr", alarm, 1'b1);
      if (i == 8) check("alarm_clr", alarm, 1'b0);
      prev_td = td;
    end

    // confirm_n=0 behaves as 1; sample equal to hi_thresh qualifies.
    confirm_n = 4'd0;
    conv(12'd3000, 3, 1'b0, ts, td);
    check("alarm_c1", alarm, 1'b1);

    // Conversion that never completes.
    wait_start(ts);
    cyc_f = -1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (fault) begin
        cyc_f = cycnt;
        break;
      end
    end
    check("timeout_cycles", cyc_f - ts, 1024);
    check("alarm_hold_to", alarm, 1'b1);
    conv(12'd2500, 4, 1'b0, ts2, td);
    check("restart_gap", ts2 - ts, 1028);
    check("fault_sticky", fault, 1'b1);
    check("alarm_mid", alarm, 1'b1);

    // enable dropped in the cycle after adc_start.
    conv(12'd3500, 5, 1'b1, ts, td);
    check("busy_idle", busy, 1'b0);
    n_st = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adc_start) n_st++;
    end
    check("no_restart", n_st, 0);

    // Spurious adc_done while idle.
    @(posedge clk); #1;
    adc_done = 1'b1;
    adc_data = 12'd123;
    @(posedge clk); #1;
    adc_done = 1'b0;
    @(negedge clk);
    check("spurious_valid", sample_valid, 1'b0);
    check("spurious_q", sample_q, 12'd3500);
    check("spurious_busy", busy, 1'b0);

    // Async reset in the middle of a conversion with alarm set.
    @(posedge clk); #1;
    enable = 1'b1;
    wait_start(ts);
    repeat (3) @(posedge clk);
    #3;
    check("alarm_before_rst", alarm, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_adc_start", adc_start, 1'b0);
    check("arst_sample_q", sample_q, 12'd0);
    check("arst_sample_valid", sample_valid, 1'b0);
    check("arst_alarm", alarm, 1'b0);
    check("arst_fault", fault, 1'b0);
    check("arst_busy", busy, 1'b0);
    m_hi = 0;
    m_lo = 0;
    m_alarm = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    r = cycnt;
    wait_start(ts);
    check("fresh_start", ts - r, 1);
    answer(12'd1500, 3, 1'b0, td);
    check("fault_after_rst", fault, 1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cycnt);
    $fatal(1);
  end

endmodule

// File: doc/pressure_sample_ctrl.md
Name: pressure_sample_ctrl

Overview:
Sequencing controller for the pressure-sensor front end. It periodically triggers an ADC conversion over a start/done handshake and latches each result into the sample register. It then applies a two-threshold, N-consecutive-sample hysteresis filter to drive a registered over-pressure alarm. A watchdog flags conversions that never complete.

Parameters:
DATA_W, 12, ADC sample width in bits
PERIOD_W, 16, width of the sample-interval counter
CONF_W, 4, width of the consecutive-sample confirm count
TIMEOUT, 1023, max cycles in CONVERT before fault (fits 10 bits)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, asynchronous, active-high
enable  input  1  run control; level-sensitive
sample_period  input  PERIOD_W  idle cycles between end of one conversion and next adc_start
hi_thresh  input  DATA_W  alarm-set threshold (unsigned)
lo_thresh  input  DATA_W  alarm-clear threshold (unsigned); caller keeps lo_thresh < hi_thresh
confirm_n  input  CONF_W  consecutive qualifying samples needed to change alarm; 0 treated as 1
adc_start  output  1  one-cycle conversion request
adc_done  input  1  one-cycle conversion-complete strobe
adc_data  input  DATA_W  conversion result, valid when adc_done=1
sample_q  output  DATA_W  last latched sample
sample_valid  output  1  one-cycle pulse when sample_q updates
alarm  output  1  filtered over-pressure flag
fault  output  1  sticky ADC timeout flag
busy  output  1  high in START or CONVERT

Behaviour:
- Reset (async, any state): state=IDLE; adc_start=0, sample_q=0, sample_valid=0, alarm=0, fault=0, busy=0; period counter, watchdog and both filter counters cleared.
- States: IDLE, WAIT, START, CONVERT.
- IDLE: enable=1 -> START next edge, so the first conversion needs no period wait.
- START: adc_start=1 for exactly this cycle; watchdog cleared; -> CONVERT.
- CONVERT:
  - adc_done=1 at edge t -> sample_q=adc_data, sample_valid=1 and filter update all at t+1 (1-cycle latency).
  - Same edge: period counter loaded with sample_period; next state is WAIT if enable=1, else IDLE.
  - Watchdog increments each cycle without adc_done. Reaching TIMEOUT -> fault=1 (sticky until reset); go to WAIT/IDLE as above; no sample_valid; filter counters and alarm unchanged.
- WAIT:
  - enable=0 -> IDLE.
  - Counter==0 -> START; otherwise decrement.
  - sample_period=0 gives adc_start 2 cycles after the adc_done cycle.
- enable drop during START/CONVERT: the conversion completes (done or timeout), then IDLE. alarm holds its value through IDLE.
- adc_done outside CONVERT: ignored; no sample_valid, no state change.
- Filter, applied on each accepted sample s:
  - s >= hi_thresh: hi_cnt++ (saturating); lo_cnt=0.
  - s <= lo_thresh: lo_cnt++ (saturating); hi_cnt=0.
  - Otherwise both counters cleared.
  - Effective confirm value c = max(confirm_n,1).
  - alarm set to 1 on the same edge hi_cnt reaches c; cleared to 0 on the same edge lo_cnt reaches c. Otherwise alarm holds.
  - Compare with the new counter value, so c=1 switches on the first qualifying sample.
- Threshold/confirm inputs are sampled only at the update edge; changes between samples take effect on the next sample.

Decomposition:
- Shared package pressure_pkg:
  - state enum (IDLE/WAIT/START/CONVERT)
  - default widths DATA_W/PERIOD_W/CONF_W
  - TIMEOUT default constant
- One sub-module: pressure_hyst_filter. Ports: clk, reset, update strobe, sample, hi/lo thresholds, confirm_n; outputs alarm. It owns hi_cnt/lo_cnt and the alarm register.

Test Plan:
- Reset, then enable=1, sample_period=3, ADC model answers 5 cycles after start. Required: adc_start pulses exactly 1 cycle apart from adc_done by 2+3=5 cycles; sample_valid exactly 1 cycle after each adc_done, with sample_q=adc_data.
- hi=3000, lo=1000, confirm_n=3; samples 3100, 3200, 2000, 3100, 3100, 3100. Required: alarm stays 0 until the 6th sample's sample_valid edge, then 1. Then samples 900, 900, 900: alarm returns to 0 on the 3rd.
- confirm_n=0, single sample 3000 (==hi): alarm=1 on that sample's update edge, since the compare is >= and c=1.
- ADC model never asserts adc_done, TIMEOUT=1023: fault=1 at 1023 cycles after CONVERT entry; no sample_valid; alarm unchanged; next adc_start follows after sample_period. A later good conversion yields sample_valid while fault stays 1.
- enable deasserted in the cycle after adc_start: adc_done still produces sample_valid; controller enters IDLE; no further adc_start. Spurious adc_done in IDLE: no sample_valid.
- reset pulsed mid-CONVERT with alarm=1: all outputs 0 immediately (async). Re-enable starts a fresh conversion with no period wait.
